// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX sides of the serial link.
package uart_pkg;
    localparam int DATA_BITS   = 8;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input int mode);
        return (mode == PARITY_ODD) ? ~(^d) : ^d;
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; tick_o marks the last cycle of each bit, clr_i restarts it.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       cnt_q <= '0;
        else if (clr_i || cnt_q == LAST) cnt_q <= '0;
        else                             cnt_q <= cnt_q + 1'b1;
    end

    assign tick_o = (cnt_q == LAST) && !clr_i;
endmodule

// File: rtl/uart_fifo.sv
// Generic synchronous byte FIFO; read data is registered and valid the cycle after the pop edge.
// Writes are dropped when full and pops are ignored when empty.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  logic [W-1:0]           wr_data_i,
    input  logic                   rd_en_i,
    output logic [W-1:0]           rd_data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [W-1:0]  rd_data_q;
    logic          wr_ok, rd_ok;

    assign wr_ok = wr_en_i && (count_q != FULL_CNT);
    assign rd_ok = rd_en_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q];
            end
            if (wr_ok && !rd_ok)      count_q <= count_q + 1'b1;
            else if (!wr_ok && rd_ok) count_q <= count_q - 1'b1;
        end
    end

    assign rd_data_o = rd_data_q;
    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_CNT);
    assign count_o   = count_q;
endmodule

// File: rtl/uart_tx_engine.sv
// Pops one byte per frame from the UART FIFO and serialises it (start, 8 data LSB-first,
// optional parity, stop). New frames start only while enable is high; a running frame always completes.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    tx_state_e      state_q;
    logic [7:0]     shift_q;
    logic [2:0]     idx_q;
    logic           par_q;
    logic           stop_q;
    logic           tx_q, rd_en_q, busy_q, done_q;
    logic           bit_tick;

    // Timer restarts in LOAD so the start bit gets a full bit period from the falling edge.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (state_q == ST_LOAD),
        .tick_o (bit_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (enable && !fifo_empty) begin
                        state_q <= ST_FETCH;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift_q <= fifo_rd_data;
                    par_q   <= parity_of(fifo_rd_data, PARITY);
                    idx_q   <= '0;
                    stop_q  <= 1'b0;
                    tx_q    <= 1'b0;
                    state_q <= ST_START;
                end
                ST_START: if (bit_tick) begin
                    tx_q    <= shift_q[0];
                    state_q <= ST_DATA;
                end
                // shift_q[0] is the bit on the line, so the next bit is always shift_q[1].
                ST_DATA: if (bit_tick) begin
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        if (PARITY != PARITY_NONE) begin
                            tx_q    <= par_q;
                            state_q <= ST_PARITY;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end
                    end else begin
                        tx_q    <= shift_q[1];
                        shift_q <= shift_q >> 1;
                        idx_q   <= idx_q + 3'd1;
                    end
                end
                ST_PARITY: if (bit_tick) begin
                    tx_q    <= 1'b1;
                    state_q <= ST_STOP;
                end
                ST_STOP: if (bit_tick) begin
                    if (int'(stop_q) == STOP_BITS - 1) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        stop_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule
